// File: rtl/mult_arbiter_4ch.sv
// Four-channel arbiter sharing one pipelined 16x16 signed multiplier, with result tagging.
// Define MULT_ARB_FIXED_PRIO_EN for fixed priority (channel 0 highest) instead of round-robin.
module mult_arbiter_4ch #(
    parameter int LATENCY = 3
) (
    input  logic               clock,
    input  logic               aclr,
    input  logic [3:0]         req,
    input  logic [63:0]        a_in,
    input  logic [63:0]        b_in,
    output logic [3:0]         gnt,
    output logic signed [15:0] mul_dataa,
    output logic signed [15:0] mul_datab,
    input  logic [31:0]        mul_result,
    output logic [31:0]        result_out,
    output logic               result_valid,
    output logic [1:0]         result_id,
    output logic [2:0]         in_flight
);

    logic [1:0] sel;
    logic       found;
    logic       issue;

`ifdef MULT_ARB_FIXED_PRIO_EN
    always_comb begin
        sel   = 2'd0;
        found = 1'b0;
        for (int k = 3; k >= 0; k--) begin
            if (req[k]) begin
                sel   = 2'(k);
                found = 1'b1;
            end
        end
    end
`else
    logic [1:0] ptr;
    logic [1:0] idx;

    always_comb begin
        sel   = 2'd0;
        found = 1'b0;
        idx   = 2'd0;
        for (int k = 0; k < 4; k++) begin
            idx = ptr + 2'(k);
            if (!found && req[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (aclr)
            ptr <= 2'd0;
        else if (issue)
            ptr <= sel + 2'd1;
    end
`endif

    assign issue     = found & ~aclr;
    assign gnt       = issue ? (4'b0001 << sel) : 4'b0000;
    assign mul_dataa = issue ? a_in[16*sel +: 16] : 16'sh0000;
    assign mul_datab = issue ? b_in[16*sel +: 16] : 16'sh0000;

    // Tag pipeline runs in lockstep with the multiplier; entry LATENCY-1 pairs with mul_result.
    logic [LATENCY-1:0]      tag_valid;
    logic [LATENCY-1:0][1:0] tag_id;

    always_ff @(posedge clock) begin
        if (aclr) begin
            tag_valid <= '0;
            tag_id    <= '0;
        end else begin
            tag_valid[0] <= issue;
            tag_id[0]    <= sel;
            for (int k = 1; k < LATENCY; k++) begin
                tag_valid[k] <= tag_valid[k-1];
                tag_id[k]    <= tag_id[k-1];
            end
        end
    end

    logic [2:0] cnt;

    always_comb begin
        cnt = 3'd0;
        for (int k = 0; k < LATENCY; k++)
            cnt = cnt + 3'(tag_valid[k]);
    end

    assign result_out   = mul_result;
    assign result_valid = tag_valid[LATENCY-1] & ~aclr;
    assign result_id    = result_valid ? tag_id[LATENCY-1] : 2'd0;
    assign in_flight    = aclr ? 3'd0 : cnt;

endmodule

// File: tb/tb_mult_arbiter_4ch.sv
// Directed self-checking bench for mult_arbiter_4ch with a 3-stage behavioural multiplier.
module tb_mult_arbiter_4ch;

    logic               clock = 1'b0;
    logic               aclr  = 1'b1;
    logic [3:0]         req   = 4'b0000;
    logic [63:0]        a_in  = '0;
    logic [63:0]        b_in  = '0;
    logic [3:0]         gnt;
    logic signed [15:0] mul_dataa;
    logic signed [15:0] mul_datab;
    logic [31:0]        mul_result;
    logic [31:0]        result_out;
    logic               result_valid;
    logic [1:0]         result_id;
    logic [2:0]         in_flight;

    int tests  = 0;
    int failed = 0;

    mult_arbiter_4ch #(.LATENCY(3)) dut (
        .clock(clock), .aclr(aclr), .req(req), .a_in(a_in), .b_in(b_in),
        .gnt(gnt), .mul_dataa(mul_dataa), .mul_datab(mul_datab),
        .mul_result(mul_result), .result_out(result_out),
        .result_valid(result_valid), .result_id(result_id), .in_flight(in_flight)
    );

    always #5 clock = ~clock;

    logic signed [31:0] p0, p1, p2;
    always_ff @(posedge clock) begin
        p0 <= mul_dataa * mul_datab;
        p1 <= p0;
        p2 <= p1;
    end
    assign mul_result = p2;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        aclr = 1'b1;
        req  = 4'b0000;
        tick();
        tick();
        aclr = 1'b0;
    endtask

    task automatic set_ops(input int ch, input logic [15:0] a, input logic [15:0] b);
        a_in[16*ch +: 16] = a;
        b_in[16*ch +: 16] = b;
    endtask

    task automatic test_reset();
        aclr = 1'b1;
        req  = 4'b1111;
        for (int ch = 0; ch < 4; ch++) set_ops(ch, 16'h0007, 16'h0009);
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            tests++;
            if (gnt !== 4'b0000) begin failed++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
            tests++;
            if (mul_dataa !== 16'sh0000 || mul_datab !== 16'sh0000) begin
                failed++; $display("FAIL reset_operands: got %h/%h want 0000/0000", mul_dataa, mul_datab);
            end
            tests++;
            if (result_valid !== 1'b0 || result_id !== 2'd0) begin
                failed++; $display("FAIL reset_result: got valid=%b id=%0d want 0/0", result_valid, result_id);
            end
            tests++;
            if (in_flight !== 3'd0) begin failed++; $display("FAIL reset_in_flight: got %0d want 0", in_flight); end
            tick();
        end
        req = 4'b0000;
    endtask

    task automatic test_single();
        logic [1:0] exp_if [5] = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd0};
        do_reset();
        a_in = '0; b_in = '0;
        set_ops(0, 16'sd3, -16'sd5);
        set_ops(1, 16'sd100, 16'sd100);
        req = 4'b0001;
        @(negedge clock);
        tests++;
        if (gnt !== 4'b0001) begin failed++; $display("FAIL single_gnt: got %b want 0001", gnt); end
        tests++;
        if (mul_dataa !== 16'sd3 || mul_datab !== -16'sd5) begin
            failed++; $display("FAIL single_operands: got %0d/%0d want 3/-5", mul_dataa, mul_datab);
        end
        tick();
        req = 4'b0000;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clock);
            tests++;
            if (result_valid !== (c == 3)) begin
                failed++; $display("FAIL single_valid_c%0d: got %b want %b", c, result_valid, (c == 3));
            end
            tests++;
            if (in_flight !== 3'(exp_if[c])) begin
                failed++; $display("FAIL single_in_flight_c%0d: got %0d want %0d", c, in_flight, exp_if[c]);
            end
            if (c == 1) begin
                tests++;
                if (gnt !== 4'b0000 || mul_dataa !== 16'sh0000) begin
                    failed++; $display("FAIL single_idle: got gnt=%b a=%h want 0000/0000", gnt, mul_dataa);
                end
            end
            if (c == 3) begin
                tests++;
                if (result_id !== 2'd0 || result_out !== 32'hFFFF_FFF1) begin
                    failed++; $display("FAIL single_result: got id=%0d out=%h want 0/fffffff1", result_id, result_out);
                end
            end
            tick();
        end
    endtask

    task automatic test_all_four();
        int         exp_prod [4] = '{-2, -6, -12, -20};
        logic [2:0] exp_if  [11] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd3, 3'd3, 3'd3, 3'd2, 3'd1};
        int         rid;
        do_reset();
        for (int ch = 0; ch < 4; ch++) set_ops(ch, 16'(ch + 1), 16'(-(ch + 2)));
        for (int c = 0; c < 11; c++) begin
            req = (c < 8) ? 4'b1111 : 4'b0000;
            @(negedge clock);
            tests++;
            if (gnt !== ((c < 8) ? (4'b0001 << (c % 4)) : 4'b0000)) begin
                failed++; $display("FAIL rr4_gnt_c%0d: got %b want ch %0d", c, gnt, c % 4);
            end
            tests++;
            if (in_flight !== exp_if[c]) begin
                failed++; $display("FAIL rr4_in_flight_c%0d: got %0d want %0d", c, in_flight, exp_if[c]);
            end
            tests++;
            if (result_valid !== (c >= 3)) begin
                failed++; $display("FAIL rr4_valid_c%0d: got %b want %b", c, result_valid, (c >= 3));
            end
            if (c >= 3) begin
                rid = (c - 3) % 4;
                tests++;
                if (result_id !== 2'(rid) || result_out !== 32'(exp_prod[rid])) begin
                    failed++;
                    $display("FAIL rr4_result_c%0d: got id=%0d out=%0d want id=%0d out=%0d",
                             c, result_id, $signed(result_out), rid, exp_prod[rid]);
                end
            end
            tick();
        end
    endtask

    task automatic test_alternate();
        do_reset();
        req = 4'b1010;
        for (int c = 0; c < 6; c++) begin
            @(negedge clock);
            tests++;
            if (gnt !== ((c % 2 == 0) ? 4'b0010 : 4'b1000)) begin
                failed++; $display("FAIL alt_gnt_c%0d: got %b want %b", c, gnt, (c % 2 == 0) ? 4'b0010 : 4'b1000);
            end
            if (c >= 3) begin
                tests++;
                if (result_valid !== 1'b1 || result_id !== ((c % 2 == 1) ? 2'd1 : 2'd3)) begin
                    failed++; $display("FAIL alt_result_c%0d: got valid=%b id=%0d", c, result_valid, result_id);
                end
            end
            tick();
        end
        req = 4'b0000;
    endtask

    task automatic test_min_operands();
        do_reset();
        for (int ch = 0; ch < 4; ch++) set_ops(ch, 16'h0101, 16'h0202);
        set_ops(2, 16'h8000, 16'h8000);
        req = 4'b0100;
        @(negedge clock);
        tests++;
        if (gnt !== 4'b0100 || mul_dataa !== 16'sh8000 || mul_datab !== 16'sh8000) begin
            failed++; $display("FAIL min_issue: got gnt=%b a=%h b=%h want 0100/8000/8000", gnt, mul_dataa, mul_datab);
        end
        tick();
        req = 4'b0000;
        tick();
        tick();
        @(negedge clock);
        tests++;
        if (result_valid !== 1'b1 || result_id !== 2'd2 || result_out !== 32'h4000_0000) begin
            failed++; $display("FAIL min_result: got valid=%b id=%0d out=%h want 1/2/40000000",
                               result_valid, result_id, result_out);
        end
        tick();
    endtask

    task automatic test_drop_req();
        do_reset();
        req = 4'b0011;
        @(negedge clock);
        tests++;
        if (gnt !== 4'b0001) begin failed++; $display("FAIL drop_gnt0: got %b want 0001", gnt); end
        tick();
        req = 4'b0001;
        @(negedge clock);
        tests++;
        if (gnt !== 4'b0001) begin failed++; $display("FAIL drop_gnt1: got %b want 0001", gnt); end
        tick();
        req = 4'b0000;
        for (int c = 2; c <= 5; c++) begin
            @(negedge clock);
            tests++;
            if (result_valid !== (c == 3 || c == 4) || result_id !== 2'd0) begin
                failed++; $display("FAIL drop_result_c%0d: got valid=%b id=%0d", c, result_valid, result_id);
            end
            tick();
        end
    endtask

    task automatic test_aclr_mid();
        do_reset();
        req = 4'b0001;
        tick();
        req = 4'b0010;
        tick();
        req  = 4'b0000;
        aclr = 1'b1;
        @(negedge clock);
        tests++;
        if (result_valid !== 1'b0 || in_flight !== 3'd0 || gnt !== 4'b0000) begin
            failed++; $display("FAIL aclr_during: got valid=%b in_flight=%0d gnt=%b", result_valid, in_flight, gnt);
        end
        tick();
        aclr = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            tests++;
            if (result_valid !== 1'b0 || in_flight !== 3'd0) begin
                failed++; $display("FAIL aclr_after_c%0d: got valid=%b in_flight=%0d want 0/0", c, result_valid, in_flight);
            end
            tick();
        end
        req = 4'b1111;
        @(negedge clock);
        tests++;
        if (gnt !== 4'b0001) begin failed++; $display("FAIL aclr_prio: got %b want 0001", gnt); end
        tick();
        req = 4'b0000;
    endtask

    task automatic test_fixed_prio();
        logic [3:0] exp_g;
        do_reset();
        req = 4'b0101;
        for (int c = 0; c < 6; c++) begin
`ifdef MULT_ARB_FIXED_PRIO_EN
            exp_g = 4'b0001;
`else
            exp_g = (c % 2 == 0) ? 4'b0001 : 4'b0100;
`endif
            @(negedge clock);
            tests++;
            if (gnt !== exp_g) begin failed++; $display("FAIL prio_gnt_c%0d: got %b want %b", c, gnt, exp_g); end
            tick();
        end
        req = 4'b0000;
    endtask

    initial begin
        test_reset();
        test_single();
        test_all_four();
        test_alternate();
        test_min_operands();
        test_drop_req();
        test_aclr_mid();
        test_fixed_prio();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/mult_arbiter_4ch.md
MULT_ARBITER_4CH -- requirements
Module: mult_arbiter_4ch

Interface
REQ-001 SHALL have parameter LATENCY, default 3: cycles from issue to the matching mul_result, matching the 16-bit signed pipelined multiplier.
REQ-002 SHALL have port clock, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port aclr, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have port req, input, 4: per-channel request; held high with operands until granted.
REQ-005 SHALL have port a_in, input, 64: channel i signed operand A at bits [16i+15:16i].
REQ-006 SHALL have port b_in, input, 64: channel i signed operand B at bits [16i+15:16i].
REQ-007 SHALL have port gnt, output, 4: one-hot grant, combinational, high for exactly the issue cycle.
REQ-008 SHALL have port mul_dataa, output, 16 (signed): operand A to the multiplier.
REQ-009 SHALL have port mul_datab, output, 16 (signed): operand B to the multiplier.
REQ-010 SHALL have port mul_result, input, 32: product from the multiplier.
REQ-011 SHALL have port result_out, output, 32: equal to mul_result.
REQ-012 SHALL have port result_valid, output, 1: result_out holds a tagged product this cycle.
REQ-013 SHALL have port result_id, output, 2: channel owning result_out; valid only with result_valid.
REQ-014 SHALL have port in_flight, output, 3: count of issued, not yet returned products, 0..LATENCY.

Function
REQ-015 SHALL issue at most one operation per cycle; issue occurs in any cycle where req != 0 and aclr = 0.
REQ-016 SHALL select by round-robin: search channels ptr, ptr+1, ... mod 4; grant the first with req high.
REQ-017 SHALL set ptr to (granted index + 1) mod 4 on each issue; ptr SHALL be unchanged when no channel is granted.
REQ-018 SHALL drive mul_dataa/mul_datab with the granted channel's operands in the issue cycle; with no grant they SHALL be 16'h0000.
REQ-019 SHALL push {valid, id} into a LATENCY-deep tag shift register every cycle; on a cycle with no issue, valid = 0.
REQ-020 SHALL assert result_valid with result_id = i exactly LATENCY cycles after channel i's issue cycle (issue at N -> return at N+LATENCY).
REQ-021 SHALL sustain full throughput: back-to-back issues in consecutive cycles return in consecutive cycles, in issue order.
REQ-022 SHALL compute in_flight as the number of valid tag entries; simultaneous issue and return leave it unchanged.
REQ-023 SHALL ignore a channel's req deasserted before grant; no issue and no result for that channel.
REQ-024 SHALL treat a channel still requesting after its grant as a new request, competing in round-robin order.
REQ-025 SHALL support any subset of req high, including a single channel that is granted every cycle.

Reset
REQ-026 SHALL, while aclr = 1: gnt = 0, result_valid = 0, result_id = 0, in_flight = 0, ptr = 0, and all tag entries invalid.
REQ-027 SHALL discard products in flight when aclr asserts mid-operation; no result_valid for them after aclr deasserts.
REQ-028 SHALL make channel 0 highest priority on the first cycle after reset.

Configuration
REQ-029 SHALL, with macro MULT_ARB_FIXED_PRIO_EN defined, use fixed priority (channel 0 highest, then 1, 2, 3); ptr SHALL be removed.
REQ-030 SHALL, without MULT_ARB_FIXED_PRIO_EN, use round-robin per REQ-016/REQ-017.
REQ-031 SHALL keep all other behaviour, including latency and tagging, identical with and without the macro.

Verification
REQ-032 SHALL cover: reset, then req=4'b0001, a=3, b=-5 -> gnt=0001 at N, and at N+3 result_valid=1, result_id=0, result_out=-15.
REQ-033 SHALL cover: req=4'b1111 held 8 cycles -> grants 0,1,2,3,0,1,2,3 in that order; results return in the same id order starting 3 cycles after the first grant, in_flight=3 in steady state.
REQ-034 SHALL cover: req=4'b1010 held -> grants alternate 1,3,1,3; ptr skips idle channels.
REQ-035 SHALL cover: channel 2 with a=-32768, b=-32768 -> result_out=32'h40000000, result_id=2.
REQ-036 SHALL cover: aclr pulsed 1 cycle after two issues -> no result_valid in the following 5 cycles (req=0), in_flight=0.
REQ-037 SHALL cover, with MULT_ARB_FIXED_PRIO_EN: req=4'b0101 held -> channel 0 granted every cycle, channel 2 never.
